// File: rtl/tape_pkg.sv
// Shared encodings for the tape head controller: FSM states and head move codes.
package tape_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_READY,
        ST_WRITE,
        ST_MOVE,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        MV_STAY  = 2'b00,
        MV_LEFT  = 2'b01,
        MV_RIGHT = 2'b10
    } move_e;

endpackage

// File: rtl/tape_ram.sv
// Single-port tape storage: synchronous write, asynchronous read on the same address, no reset.
module tape_ram #(
    parameter int unsigned SYM_W = 3,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned POS_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [POS_W-1:0] addr_i,
    input  logic [SYM_W-1:0] wdata_i,
    output logic [SYM_W-1:0] rdata_o
);

    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/tape_head_controller.sv
// Tape head controller: blank-fill sweep after reset/clear, then fixed three-cycle
// accept/write/move step cadence with edge wrap or sticky fault.
module tape_head_controller
    import tape_pkg::*;
#(
    parameter int unsigned      SYM_W     = 3,
    parameter int unsigned      DEPTH     = 512,
    parameter int unsigned      POS_W     = $clog2(DEPTH),
    parameter int unsigned      START_POS = 332,
    parameter logic [SYM_W-1:0] BLANK     = '0,
    parameter bit               WRAP      = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic             write_en,
    input  logic [SYM_W-1:0] new_sym,
    input  logic [1:0]       move,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic [POS_W-1:0] position,
    output logic             at_left,
    output logic             at_right,
    output logic             fault
);

    localparam logic [POS_W-1:0] LAST  = POS_W'(DEPTH - 1);
    localparam logic [POS_W-1:0] START = POS_W'(START_POS);

    state_e           state_q, state_d;
    logic [POS_W-1:0] sweep_q, sweep_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             fault_q, fault_d;
    logic             we_q, we_d;
    logic [SYM_W-1:0] nsym_q, nsym_d;
    logic [1:0]       move_q, move_d;

    logic             ram_we;
    logic [POS_W-1:0] ram_addr;
    logic [SYM_W-1:0] ram_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            pos_q   <= START;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
            nsym_q  <= '0;
            move_q  <= MV_STAY;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            pos_q   <= pos_d;
            fault_q <= fault_d;
            we_q    <= we_d;
            nsym_q  <= nsym_d;
            move_q  <= move_d;
        end
    end

    // clear overrides every state, so it is decided before the per-state logic.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        pos_d     = pos_q;
        fault_d   = fault_q;
        we_d      = we_q;
        nsym_d    = nsym_q;
        move_d    = move_q;
        ram_we    = 1'b0;
        ram_addr  = pos_q;
        ram_wdata = nsym_q;

        if (clear) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
            pos_d   = START;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = sweep_q;
                    ram_wdata = BLANK;
                    if (sweep_q == LAST) begin
                        state_d = ST_READY;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (step_valid) begin
                        we_d    = write_en;
                        nsym_d  = new_sym;
                        move_d  = move;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ram_we  = we_q;
                    state_d = ST_MOVE;
                end
                ST_MOVE: begin
                    state_d = ST_READY;
                    if (move_q == MV_LEFT) begin
                        if (pos_q != '0) begin
                            pos_d = pos_q - 1'b1;
                        end else if (WRAP) begin
                            pos_d = LAST;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end
                    end else if (move_q == MV_RIGHT) begin
                        if (pos_q != LAST) begin
                            pos_d = pos_q + 1'b1;
                        end else if (WRAP) begin
                            pos_d = '0;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            endcase
        end
    end

    tape_ram #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .POS_W (POS_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (sym)
    );

    assign sym_valid  = (state_q == ST_READY);
    assign step_ready = sym_valid && !clear;
    assign position   = pos_q;
    assign at_left    = (pos_q == '0);
    assign at_right   = (pos_q == LAST);
    assign fault      = fault_q;

endmodule

// File: tb/tb_tape_head_controller.sv
// Drives one stimulus stream into a WRAP=0 and a WRAP=1 controller and checks both every
// cycle against a transaction-level tape model, plus hand-computed literal expectations.
module tb_tape_head_controller;

    localparam int DEPTH = 16;
    localparam int START = 5;

    logic clock = 1'b0;
    logic reset_n;
    logic clear;
    logic step_valid;
    logic write_en;
    logic [2:0] new_sym;
    logic [1:0] move;

    logic [1:0]      rdy, sv, al, ar, flt;
    logic [1:0][3:0] pos;
    logic [1:0][2:0] sym;

    int checks = 0;
    int failures = 0;

    int mTape [2][DEPTH];
    int mPos [2];
    int mFault [2];
    int mSweep [2];
    int mBusy [2];
    int mWe [2];
    int mSym [2];
    int mMove [2];

    always #5 clock = ~clock;

    tape_head_controller #(.SYM_W(3), .DEPTH(DEPTH), .START_POS(START), .BLANK(3'd0), .WRAP(1'b0)) dut_nw (
        .clock(clock), .reset_n(reset_n), .clear(clear), .step_valid(step_valid),
        .step_ready(rdy[0]), .write_en(write_en), .new_sym(new_sym), .move(move),
        .sym(sym[0]), .sym_valid(sv[0]), .position(pos[0]), .at_left(al[0]),
        .at_right(ar[0]), .fault(flt[0]));

    tape_head_controller #(.SYM_W(3), .DEPTH(DEPTH), .START_POS(START), .BLANK(3'd0), .WRAP(1'b1)) dut_w (
        .clock(clock), .reset_n(reset_n), .clear(clear), .step_valid(step_valid),
        .step_ready(rdy[1]), .write_en(write_en), .new_sym(new_sym), .move(move),
        .sym(sym[1]), .sym_valid(sv[1]), .position(pos[1]), .at_left(al[1]),
        .at_right(ar[1]), .fault(flt[1]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset(input int k);
        mSweep[k] = DEPTH;
        mPos[k]   = START;
        mFault[k] = 0;
        mBusy[k]  = 0;
    endtask

    // One clock edge of the abstract tape: k=1 is the wrapping instance.
    task automatic modelEdge(input int k);
        int target;
        if (clear) begin
            modelReset(k);
        end else if (mSweep[k] > 0) begin
            mSweep[k]--;
            if (mSweep[k] == 0)
                for (int i = 0; i < DEPTH; i++) mTape[k][i] = 0;
        end else if (mFault[k] != 0) begin
            target = 0;
        end else if (mBusy[k] == 2) begin
            if (mWe[k] != 0) mTape[k][mPos[k]] = mSym[k];
            mBusy[k] = 1;
        end else if (mBusy[k] == 1) begin
            mBusy[k] = 0;
            target = mPos[k] + ((mMove[k] == 1) ? -1 : (mMove[k] == 2) ? 1 : 0);
            if (target < 0 || target >= DEPTH) begin
                if (k == 1) mPos[k] = (target + DEPTH) % DEPTH;
                else        mFault[k] = 1;
            end else begin
                mPos[k] = target;
            end
        end else if (step_valid) begin
            mWe[k]   = int'(write_en);
            mSym[k]  = int'(new_sym);
            mMove[k] = int'(move);
            mBusy[k] = 2;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) modelReset(k);
            else          modelEdge(k);
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                automatic bit idle = (mSweep[k] == 0) && (mFault[k] == 0) && (mBusy[k] == 0);
                checkOutput($sformatf("dut%0d.sym_valid", k), 32'(sv[k]), 32'(idle));
                checkOutput($sformatf("dut%0d.step_ready", k), 32'(rdy[k]), 32'(idle && !clear));
                checkOutput($sformatf("dut%0d.position", k), 32'(pos[k]), 32'(mPos[k]));
                checkOutput($sformatf("dut%0d.at_left", k), 32'(al[k]), 32'(mPos[k] == 0));
                checkOutput($sformatf("dut%0d.at_right", k), 32'(ar[k]), 32'(mPos[k] == DEPTH - 1));
                checkOutput($sformatf("dut%0d.fault", k), 32'(flt[k]), 32'(mFault[k]));
                if (idle)
                    checkOutput($sformatf("dut%0d.sym", k), 32'(sym[k]), 32'(mTape[k][mPos[k]]));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offer a step for one cycle, then scramble the inputs while the step is in flight.
    task automatic applyStimulus(input logic we, input logic [2:0] s, input logic [1:0] m);
        step_valid = 1'b1;
        write_en   = we;
        new_sym    = s;
        move       = m;
        waitCycles(1);
        step_valid = 1'b0;
        write_en   = ~we;
        new_sym    = ~s;
        move       = ~m;
        waitCycles(2);
        write_en   = 1'b0;
        new_sym    = 3'd0;
        move       = 2'b00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) mTape[k][i] = 0;
        reset_n = 1'b0; clear = 1'b0; step_valid = 1'b0;
        write_en = 1'b0; new_sym = 3'd0; move = 2'b00;

        // Reset state and post-reset sweep timing.
        waitCycles(2);
        checkOutput("rst.step_ready", 32'(rdy[0]), 0);
        checkOutput("rst.sym_valid", 32'(sv[0]), 0);
        checkOutput("rst.position", 32'(pos[0]), 5);
        checkOutput("rst.fault", 32'(flt[0]), 0);
        reset_n = 1'b1;
        waitCycles(15);
        checkOutput("sweep15.step_ready", 32'(rdy[0]), 0);
        waitCycles(1);
        checkOutput("sweep16.step_ready", 32'(rdy[0]), 1);
        checkOutput("sweep16.sym_valid", 32'(sv[1]), 1);
        checkOutput("sweep16.sym", 32'(sym[0]), 0);

        // Write then move right, then come back and read the written symbol.
        applyStimulus(1'b1, 3'd6, 2'b10);
        checkOutput("stepR.position", 32'(pos[0]), 6);
        checkOutput("stepR.sym", 32'(sym[0]), 0);
        applyStimulus(1'b0, 3'd3, 2'b01);
        checkOutput("stepL.position", 32'(pos[1]), 5);
        checkOutput("stepL.sym", 32'(sym[0]), 6);

        // Walk to the left edge, then step off it.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'd0, 2'b01);
        checkOutput("walk.at_left", 32'(al[0]), 1);
        applyStimulus(1'b1, 3'd2, 2'b01);
        checkOutput("edge.nw.fault", 32'(flt[0]), 1);
        checkOutput("edge.nw.position", 32'(pos[0]), 0);
        checkOutput("edge.nw.step_ready", 32'(rdy[0]), 0);
        checkOutput("edge.w.position", 32'(pos[1]), 15);
        checkOutput("edge.w.fault", 32'(flt[1]), 0);

        // Wrapping instance crosses the right edge and back; halted instance ignores it.
        applyStimulus(1'b0, 3'd0, 2'b10);
        checkOutput("wrapR.position", 32'(pos[1]), 0);
        checkOutput("wrapR.sym", 32'(sym[1]), 2);
        checkOutput("wrapR.nw.position", 32'(pos[0]), 0);
        applyStimulus(1'b0, 3'd0, 2'b01);
        checkOutput("wrapL.position", 32'(pos[1]), 15);

        // Clear out of HALT.
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        checkOutput("clr.fault", 32'(flt[0]), 0);
        checkOutput("clr.position", 32'(pos[0]), 5);
        waitCycles(15);
        checkOutput("clr15.step_ready", 32'(rdy[0]), 0);
        waitCycles(1);
        checkOutput("clr16.step_ready", 32'(rdy[0]), 1);

        // Clear during the WRITE cycle abandons the step.
        step_valid = 1'b1; write_en = 1'b1; new_sym = 3'd7; move = 2'b00;
        waitCycles(1);
        step_valid = 1'b0; write_en = 1'b0; clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        waitCycles(16);
        checkOutput("clrW.sym", 32'(sym[0]), 0);
        checkOutput("clrW.position", 32'(pos[0]), 5);

        // Clear together with step_valid in READY, clear held three cycles.
        clear = 1'b1; step_valid = 1'b1; write_en = 1'b1; new_sym = 3'd3; move = 2'b10;
        #1;
        checkOutput("clrV.step_ready", 32'(rdy[0]), 0);
        checkOutput("clrV.sym_valid", 32'(sv[0]), 1);
        waitCycles(1);
        step_valid = 1'b0; write_en = 1'b0; move = 2'b00;
        waitCycles(2);
        clear = 1'b0;
        waitCycles(15);
        checkOutput("hold15.sym_valid", 32'(sv[0]), 0);
        waitCycles(1);
        checkOutput("hold16.position", 32'(pos[0]), 5);
        checkOutput("hold16.step_ready", 32'(rdy[1]), 1);

        // Asynchronous reset in the middle of a MOVE.
        applyStimulus(1'b0, 3'd0, 2'b10);
        checkOutput("pre.position", 32'(pos[0]), 6);
        step_valid = 1'b1; move = 2'b10;
        waitCycles(1);
        step_valid = 1'b0; move = 2'b00;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst.position", 32'(pos[0]), 5);
        checkOutput("arst.sym_valid", 32'(sv[1]), 0);
        checkOutput("arst.step_ready", 32'(rdy[0]), 0);
        checkOutput("arst.fault", 32'(flt[0]), 0);
        #3 reset_n = 1'b1;
        waitCycles(15);
        checkOutput("arst15.step_ready", 32'(rdy[0]), 0);
        waitCycles(1);
        checkOutput("arst16.step_ready", 32'(rdy[0]), 1);
        applyStimulus(1'b0, 3'd0, 2'b11);
        checkOutput("mv11.position", 32'(pos[0]), 5);
        checkOutput("mv11.sym_valid", 32'(sv[0]), 1);

        waitCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
